// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU arbiter: op codes, FSM encoding and
// the fixed result constants.
package alu_pkg;

    localparam logic [2:0] OP_ADDRIP = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_LOGIC  = 3'd2;
    localparam logic [2:0] OP_ANY    = 3'd3;
    localparam logic [2:0] OP_PRED   = 3'd4;
    localparam logic [2:0] OP_CAT    = 3'd5;
    localparam logic [2:0] OP_RSVD   = 3'd6;
    localparam logic [2:0] OP_NOP    = 3'd7;

    localparam logic [7:0] RES_PRED = 8'h70;
    localparam logic [7:0] RES_ANY  = 8'h0F;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational result function for the arbiter; all inputs come from the
// arbiter's capture registers.
module alu_core
    import alu_pkg::*;
(
    input  logic [2:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] y
);

    logic [4:0] w_rip;
    logic [4:0] w_sum;

    // Explicit full-adder chain for the ripple-carry op.
    always_comb begin : ripple
        logic carry;
        carry = 1'b0;
        w_rip = '0;
        for (int i = 0; i < 4; i++) begin
            w_rip[i] = a[i] ^ b[i] ^ carry;
            carry    = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        w_rip[4] = carry;
    end

    assign w_sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        y = 8'h00;
        case (op)
            OP_ADDRIP: y = {3'b000, w_rip};
            OP_ADD:    y = {3'b000, w_sum};
            OP_LOGIC:  y = {~(a & b), ~(a ^ b)};
            OP_ANY:    y = (|{a, b}) ? RES_ANY : 8'h00;
            OP_PRED:   y = (popcnt4(a) == 3'd1 && popcnt4(b) == 3'd2) ? RES_PRED : 8'h00;
            OP_CAT:    y = {a, ~b};
            default:   y = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end to a shared ALU: capture in IDLE, grant in
// EXEC, hold the registered result in DONE until acknowledged.
module alu_rr_arbiter
    import alu_pkg::*;
(
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       ReqA,
    input  logic       ReqB,
    input  logic [2:0] OpA,
    input  logic [2:0] OpB,
    input  logic [3:0] AA,
    input  logic [3:0] BA,
    input  logic [3:0] AB,
    input  logic [3:0] BB,
    input  logic       Ack,
    output logic       GntA,
    output logic       GntB,
    output logic [7:0] Result,
    output logic       ResultValid,
    output logic       ResultOwner,
    output logic       Busy
);

    state_e     r_state;
    state_e     w_state_d;
    logic [2:0] r_op;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_win;
    logic       r_last;
    logic [7:0] r_result;
    logic       r_valid;
    logic       r_owner;

    logic       w_capture;
    logic       w_finish;
    logic       w_release;
    logic       w_win_b;
    logic [7:0] w_y;

    // On a tie the requester that did not win last time gets the grant.
    assign w_win_b = (ReqA & ReqB) ? ~r_last : ReqB;

    always_comb begin
        w_state_d = r_state;
        w_capture = 1'b0;
        w_finish  = 1'b0;
        w_release = 1'b0;
        case (r_state)
            StIdle: begin
                if (ReqA | ReqB) begin
                    w_capture = 1'b1;
                    w_state_d = StExec;
                end
            end
            StExec: begin
                w_finish  = 1'b1;
                w_state_d = StDone;
            end
            StDone: begin
                if (Ack) begin
                    w_release = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_op     <= OP_ADDRIP;
            r_a      <= 4'h0;
            r_b      <= 4'h0;
            r_win    <= 1'b0;
            r_last   <= 1'b1;
            r_result <= 8'h00;
            r_valid  <= 1'b0;
            r_owner  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_op   <= w_win_b ? OpB : OpA;
                r_a    <= w_win_b ? AB : AA;
                r_b    <= w_win_b ? BB : BA;
                r_win  <= w_win_b;
                r_last <= w_win_b;
            end
            if (w_finish) begin
                r_result <= w_y;
                r_owner  <= r_win;
                r_valid  <= 1'b1;
            end
            if (w_release) begin
                r_valid <= 1'b0;
            end
        end
    end

    alu_core u_alu_core (
        .op (r_op),
        .a  (r_a),
        .b  (r_b),
        .y  (w_y)
    );

    assign GntA        = (r_state == StExec) & ~r_win;
    assign GntB        = (r_state == StExec) & r_win;
    assign Busy        = (r_state != StIdle);
    assign Result      = r_result;
    assign ResultValid = r_valid;
    assign ResultOwner = r_owner;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Randomized transaction-level bench for alu_rr_arbiter with a behavioural
// arbitration/ALU model plus directed reset, tie and op cases.
module tb_alu_rr_arbiter;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       ReqA, ReqB;
    logic [2:0] OpA, OpB;
    logic [3:0] AA, BA, AB, BB;
    logic       Ack;
    logic       GntA, GntB;
    logic [7:0] Result;
    logic       ResultValid, ResultOwner, Busy;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit pend_a, pend_b, last_b;

    alu_rr_arbiter dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .ReqA        (ReqA),
        .ReqB        (ReqB),
        .OpA         (OpA),
        .OpB         (OpB),
        .AA          (AA),
        .BA          (BA),
        .AB          (AB),
        .BB          (BB),
        .Ack         (Ack),
        .GntA        (GntA),
        .GntB        (GntB),
        .Result      (Result),
        .ResultValid (ResultValid),
        .ResultOwner (ResultOwner),
        .Busy        (Busy)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
        int ia = int'(a);
        int ib = int'(b);
        case (op)
            3'd0, 3'd1: return 8'(ia + ib);
            3'd2:       return 8'((15 - (ia & ib)) * 16 + (15 - (ia ^ ib)));
            3'd3:       return ((ia | ib) != 0) ? 8'h0F : 8'h00;
            3'd4:       return ($countones(a) == 1 && $countones(b) == 2) ? 8'h70 : 8'h00;
            3'd5:       return 8'(ia * 16 + (15 - ib));
            default:    return 8'h00;
        endcase
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, 8'({GntA, GntB}), 8'd0);
        chk({tag, "_valid"}, 8'(ResultValid), 8'd0);
        chk({tag, "_busy"}, 8'(Busy), 8'd0);
    endtask

    task automatic do_reset;
        Resetn = 1'b0;
        ReqA = 1'b0; ReqB = 1'b0; Ack = 1'b0;
        pend_a = 1'b0; pend_b = 1'b0; last_b = 1'b1;
        tick;
        Resetn = 1'b1;
    endtask

    // One full transaction from IDLE back to IDLE; leaves the loser's request pending.
    task automatic run_op(input bit new_a, input bit new_b, input logic [2:0] opa,
                          input logic [3:0] aa, input logic [3:0] ba, input logic [2:0] opb,
                          input logic [3:0] ab, input logic [3:0] bb, input int hold,
                          output bit win_b, output int gnt_cyc);
        logic [7:0] exp;
        pend_a = pend_a | new_a;
        pend_b = pend_b | new_b;
        if (!pend_a && !pend_b) pend_a = 1'b1;
        ReqA = pend_a; ReqB = pend_b;
        OpA = opa; AA = aa; BA = ba;
        OpB = opb; AB = ab; BB = bb;
        Ack = 1'($urandom_range(0, 1));
        win_b  = (pend_a && pend_b) ? !last_b : pend_b;
        last_b = win_b;
        exp    = win_b ? ref_alu(opb, ab, bb) : ref_alu(opa, aa, ba);
        tick;
        gnt_cyc = cyc;
        chk("exec_gnt_a", 8'(GntA), 8'(!win_b));
        chk("exec_gnt_b", 8'(GntB), 8'(win_b));
        chk("exec_busy", 8'(Busy), 8'd1);
        chk("exec_valid", 8'(ResultValid), 8'd0);
        if (win_b) pend_b = 1'b0;
        else       pend_a = 1'b0;
        ReqA = pend_a; ReqB = pend_b;
        OpA = 3'($urandom); AA = 4'($urandom); BA = 4'($urandom);
        OpB = 3'($urandom); AB = 4'($urandom); BB = 4'($urandom);
        Ack = 1'($urandom_range(0, 1));
        tick;
        for (int h = 0; h <= hold; h++) begin
            chk("done_valid", 8'(ResultValid), 8'd1);
            chk("done_result", Result, exp);
            chk("done_owner", 8'(ResultOwner), 8'(win_b));
            chk("done_gnt", 8'({GntA, GntB}), 8'd0);
            chk("done_busy", 8'(Busy), 8'd1);
            if (h == hold) begin
                Ack = 1'b1;
            end else begin
                Ack = 1'b0;
                if ($urandom_range(0, 3) == 0) pend_a = 1'b1;
                if ($urandom_range(0, 3) == 0) pend_b = 1'b1;
                ReqA = pend_a; ReqB = pend_b;
            end
            tick;
        end
        chk_idle("release");
        Ack = 1'b0;
    endtask

    initial begin
        bit w;
        int gc;
        int g[4];
        Resetn = 1'b0;
        ReqA = 1'b0; ReqB = 1'b0; Ack = 1'b0;
        OpA = 3'd0; OpB = 3'd0; AA = 4'd0; BA = 4'd0; AB = 4'd0; BB = 4'd0;
        pend_a = 1'b0; pend_b = 1'b0; last_b = 1'b1;
        #12;
        chk_idle("por");
        chk("por_result", Result, 8'h00);
        chk("por_owner", 8'(ResultOwner), 8'd0);
        tick;
        Resetn = 1'b1;
        tick;

        // Single add held for five cycles without Ack.
        run_op(1'b1, 1'b0, 3'd0, 4'hF, 4'h1, 3'd0, 4'h0, 4'h0, 5, w, gc);
        chk("single_owner_a", 8'(w), 8'd0);

        // Logic op from requester B.
        do_reset;
        run_op(1'b0, 1'b1, 3'd0, 4'h0, 4'h0, 3'd2, 4'hC, 4'hA, 1, w, gc);
        chk("logic_owner_b", 8'(w), 8'd1);

        // Predicate and constant-result ops.
        do_reset;
        run_op(1'b1, 1'b0, 3'd4, 4'h4, 4'h5, 3'd0, 4'h0, 4'h0, 0, w, gc);
        run_op(1'b1, 1'b0, 3'd4, 4'h3, 4'h5, 3'd0, 4'h0, 4'h0, 0, w, gc);
        run_op(1'b1, 1'b0, 3'd4, 4'h4, 4'hF, 3'd0, 4'h0, 4'h0, 0, w, gc);
        run_op(1'b1, 1'b0, 3'd3, 4'h0, 4'h0, 3'd0, 4'h0, 4'h0, 0, w, gc);
        run_op(1'b1, 1'b0, 3'd6, 4'h7, 4'h9, 3'd0, 4'h0, 4'h0, 0, w, gc);

        // Tie with Ack high: A, B, A, B at three-cycle spacing.
        do_reset;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b1, 1'b1, 3'd1, 4'(i), 4'h3, 3'd5, 4'(i), 4'h6, 0, w, g[i]);
            chk("tie_order", 8'(w), 8'(i % 2));
            if (i > 0) chk("tie_spacing", 8'(g[i] - g[i-1]), 8'd3);
        end

        // Reset while in DONE: outputs clear with no clock edge.
        do_reset;
        ReqA = 1'b1; OpA = 3'd1; AA = 4'h9; BA = 4'h9;
        tick;
        ReqA = 1'b0;
        tick;
        chk("pre_rst_valid", 8'(ResultValid), 8'd1);
        #2 Resetn = 1'b0;
        #1;
        chk_idle("rst_done");
        chk("rst_done_result", Result, 8'h00);
        tick;
        Resetn = 1'b1;
        tick;
        chk_idle("rst_done_after");

        // Reset while in EXEC discards the operation.
        ReqB = 1'b1; OpB = 3'd5; AB = 4'h2; BB = 4'h2;
        tick;
        ReqB = 1'b0;
        #2 Resetn = 1'b0;
        #1;
        chk_idle("rst_exec");
        tick;
        Resetn = 1'b1;
        tick;
        chk_idle("rst_exec_after1");
        tick;
        chk_idle("rst_exec_after2");
        pend_a = 1'b0; pend_b = 1'b0; last_b = 1'b1;
        run_op(1'b1, 1'b0, 3'd1, 4'h5, 4'h6, 3'd0, 4'h0, 4'h0, 0, w, gc);
        chk("post_rst_gnt_a", 8'(w), 8'd0);

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   3'($urandom), 4'($urandom), 4'($urandom),
                   3'($urandom), 4'($urandom), 4'($urandom),
                   int'($urandom_range(0, 2)), w, gc);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

Interface
REQ-001 The block SHALL have the following ports (name, direction, width, meaning):
REQ-002 Clock  in  1  single clock; all state updates on the rising edge.
REQ-003 Resetn  in  1  reset, asynchronous and active-low.
REQ-004 ReqA, ReqB  in  1 each  requester A/B operation request; held high until the matching grant.
REQ-005 OpA, OpB  in  3 each  operation code of requester A/B.
REQ-006 AA, BA, AB, BB  in  4 each  operands A and B of requester A (AA, BA) and of requester B (AB, BB).
REQ-007 Ack  in  1  result consumer acknowledge; sampled only while ResultValid=1.
REQ-008 GntA, GntB  out  1 each  one-cycle grant pulse to the winning requester.
REQ-009 Result  out  8  registered ALU result.
REQ-010 ResultValid  out  1  Result holds a completed operation.
REQ-011 ResultOwner  out  1  requester that owns Result: 0 = A, 1 = B.
REQ-012 Busy  out  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-014 IDLE: on an edge with ReqA or ReqB high, capture the winner's Op and operands, record the winner, and go to EXEC; with no request, stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: a lone request always wins; with both requests high, the requester that did not win last wins; the last-winner pointer updates on each grant.
REQ-016 In EXEC the winner's Gnt output SHALL be high for exactly that one cycle, and the other Gnt SHALL stay low.
REQ-017 At the end of EXEC the block SHALL register Result and ResultOwner, set ResultValid, and go to DONE.
REQ-018 In DONE, ResultValid and Result SHALL be held stable until Ack is sampled high; on that edge ResultValid clears and the FSM returns to IDLE.
REQ-019 Latency: request sampled on edge k, Gnt high in cycle k+1, ResultValid high from cycle k+2; with Ack tied high, one operation completes every 3 cycles.
REQ-020 Requests arriving in EXEC or DONE SHALL be ignored and no state recorded; a request still held is re-arbitrated in IDLE.
REQ-021 Ack outside DONE SHALL have no effect.
REQ-022 The result function (A, B = captured operands; all widths zero-extended to 8 bits) SHALL be:
  - op0: ripple-carry sum A+B, 5 bits.
  - op1: A+B, 5 bits.
  - op2: {~(A&B), ~(A^B)}.
  - op3: 0x0F if any bit of {A,B} is set, else 0x00.
  - op4: 0x70 if A has exactly one bit set AND B has exactly two bits set, else 0x00.
  - op5: {A, ~B}.
  - op6, op7: 0x00.
REQ-023 Operands and Op SHALL come only from the captured registers; input changes after capture SHALL NOT affect Result.

Reset
REQ-024 On Resetn low the block SHALL immediately set: FSM = IDLE, GntA = GntB = 0, Result = 0x00, ResultValid = 0, ResultOwner = 0, Busy = 0, last-winner pointer = B (so A wins the first tie).
REQ-025 Reset during EXEC or DONE SHALL discard the in-flight operation, with no grant or result emitted for it after reset release.

Structure
REQ-026 A shared package alu_pkg SHALL hold the op-code constants (OP_ADDRIP..OP_NOP), the state encoding, and the constant 0x70 / 0x0F result values.
REQ-027 The result function SHALL be a combinational sub-module alu_core (inputs op[2:0], a[3:0], b[3:0]; output y[7:0]) instantiated once; the arbiter/FSM SHALL hold all registers.

Verification
REQ-028 Reset: Resetn=0 during DONE -> ResultValid, Result, GntA/B and Busy are 0 without waiting for a clock edge; after release, ReqA gives GntA two cycles later.
REQ-029 Single op: ReqA=1, OpA=0, AA=0xF, BA=0x1 -> GntA in cycle k+1; Result=0x10, ResultOwner=0 from k+2; both held with Ack=0 for 5 cycles; cleared the edge after Ack=1.
REQ-030 Tie: ReqA=ReqB=1 held, Ack=1 -> grant order A, B, A, B, with grant pulses spaced 3 cycles apart.
REQ-031 Logic op: OpB=2, AB=0xC, BB=0xA -> Result=0x79, ResultOwner=1.
REQ-032 Predicate op: op4 with A=0x4, B=0x5 -> 0x70; with A=0x3, B=0x5 -> 0x00; with A=0x4, B=0xF -> 0x00; op3 with A=B=0 -> 0x00; op6 -> 0x00.
REQ-033 Operand hold: change AA/BA during EXEC -> Result reflects the values captured in IDLE; ReqB asserted during DONE -> no GntB until after the FSM returns to IDLE.
